// File: rtl/mips_alu.sv
// mips_alu: single-cycle MIPS integer execute unit with registered result and HI/LO next-state.
// Define MULDIV_EN to build MULT/MULTU/DIV/DIVU; otherwise those codes act as unknown.
module mips_alu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [5:0]  ALU_control,
    input  logic [4:0]  shiftAmount,
    input  logic [31:0] HI_IN,
    input  logic [31:0] LO_IN,
    output logic [31:0] aluResult,
    output logic [31:0] HI_OUT,
    output logic [31:0] LO_OUT
);
    logic [31:0] res, hi, lo;
    logic [4:0]  sa;
`ifdef MULDIV_EN
    logic [63:0] smul, umul;
    logic [31:0] dv, sq, sr, uq, ur;
    logic        dz;
    assign smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign umul = {32'b0, A} * {32'b0, B};
    // A zero divisor is replaced by 1 so the divider never faults; the result is overridden below.
    // With divisor 1, 0x80000000 / -1 is never formed, and the quotient A / 1 is exactly 0x80000000.
    assign dz = (B == 32'd0);
    assign dv = (dz || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) ? 32'd1 : B;
    assign sq = $signed(A) / $signed(dv);
    assign sr = $signed(A) % $signed(dv);
    assign uq = A / dv;
    assign ur = A % dv;
`endif
    always_comb begin
        res = '0;
        hi  = HI_IN;
        lo  = LO_IN;
        sa  = (ALU_control >= 6'h0D) ? A[4:0] : shiftAmount;
        case (ALU_control)
            6'h00, 6'h01: res = A + B;
            6'h02, 6'h03: res = A - B;
            6'h04:        res = A & B;
            6'h05:        res = A | B;
            6'h06:        res = A ^ B;
            6'h07:        res = ~(A | B);
            6'h08:        res = {31'b0, $signed(A) < $signed(B)};
            6'h09:        res = {31'b0, A < B};
            6'h0A, 6'h0D: res = B << sa;
            6'h0B, 6'h0E: res = B >> sa;
            6'h0C, 6'h0F: res = $signed(B) >>> sa;
            6'h10:        res = {B[15:0], 16'h0};
            6'h11:        res = HI_IN;
            6'h12:        res = LO_IN;
            6'h13:        hi = A;
            6'h14:        lo = A;
`ifdef MULDIV_EN
            6'h15:        {hi, lo} = smul;
            6'h16:        {hi, lo} = umul;
            6'h17:        {hi, lo} = dz ? {A, 32'hFFFF_FFFF} : {sr, sq};
            6'h18:        {hi, lo} = dz ? {A, 32'hFFFF_FFFF} : {ur, uq};
`endif
            6'h19:        res = A;
            6'h1A:        res = B;
            default:      res = '0;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            aluResult <= '0;
            HI_OUT    <= '0;
            LO_OUT    <= '0;
        end else begin
            aluResult <= res;
            HI_OUT    <= hi;
            LO_OUT    <= lo;
        end
    end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed and randomized checks of mips_alu against an arithmetic reference model.
module tb_mips_alu;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] A = '0, B = '0, HI_IN = '0, LO_IN = '0;
    logic [5:0]  ALU_control = '0;
    logic [4:0]  shiftAmount = '0;
    logic [31:0] aluResult, HI_OUT, LO_OUT;
    int passed = 0;
    int total = 0;

    mips_alu dut (
        .CLK(CLK), .RESET(RESET), .A(A), .B(B), .ALU_control(ALU_control),
        .shiftAmount(shiftAmount), .HI_IN(HI_IN), .LO_IN(LO_IN),
        .aluResult(aluResult), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [31:0] hi, input logic [31:0] lo);
        @(negedge CLK);
        ALU_control = op; A = a; B = b; shiftAmount = s; HI_IN = hi; LO_IN = lo;
        @(posedge CLK);
        #1;
    endtask

    function automatic void model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] s, input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] r, output logic [31:0] h, output logic [31:0] l);
        longint as_ = longint'($signed(a));
        longint bs  = longint'($signed(b));
        longint au  = longint'({32'b0, a});
        longint bu  = longint'({32'b0, b});
        longint p   = longint'(1) << ((op >= 6'h0D && op <= 6'h0F) ? int'(a[4:0]) : int'(s));
        logic [63:0] w;
        r = '0; h = hi; l = lo;
        case (op)
            6'h00, 6'h01: r = 32'(au + bu);
            6'h02, 6'h03: r = 32'(au - bu);
            6'h04: r = a & b;
            6'h05: r = a | b;
            6'h06: r = a ^ b;
            6'h07: r = ~(a | b);
            6'h08: r = (as_ < bs) ? 32'd1 : 32'd0;
            6'h09: r = (au < bu) ? 32'd1 : 32'd0;
            6'h0A, 6'h0D: r = 32'(bu * p);
            6'h0B, 6'h0E: r = 32'(bu / p);
            6'h0C, 6'h0F: r = 32'((bs >= 0) ? bs / p : (bs - p + 1) / p);
            6'h10: r = 32'(bu * 65536);
            6'h11: r = hi;
            6'h12: r = lo;
            6'h13: h = a;
            6'h14: l = a;
`ifdef MULDIV_EN
            6'h15: begin w = 64'(as_ * bs); h = w[63:32]; l = w[31:0]; end
            6'h16: begin w = 64'(au * bu); h = w[63:32]; l = w[31:0]; end
            6'h17: if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                   else begin l = 32'(as_ / bs); h = 32'(as_ % bs); end
            6'h18: if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                   else begin l = 32'(au / bu); h = 32'(au % bu); end
`endif
            6'h19: r = a;
            6'h1A: r = b;
            default: r = '0;
        endcase
    endfunction

    task automatic test_reset;
        drive(6'h00, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0);
        #2 RESET = 1'b1;
        #1;
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== 96'd0)
            $display("FAIL reset_async: got %h required 0", {aluResult, HI_OUT, LO_OUT});
        else passed++;
        @(posedge CLK);
        #1;
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== 96'd0)
            $display("FAIL reset_hold: got %h required 0", {aluResult, HI_OUT, LO_OUT});
        else passed++;
        @(negedge CLK) RESET = 1'b0;
        @(posedge CLK);
        #1;
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== {32'd12, 64'd0})
            $display("FAIL reset_release: got %h required %h", {aluResult, HI_OUT, LO_OUT}, {32'd12, 64'd0});
        else passed++;
    endtask

    task automatic test_arith;
        logic [5:0]  ops [4] = '{6'h00, 6'h08, 6'h09, 6'h02};
        logic [31:0] exp [4] = '{32'h0, 32'h1, 32'h0, 32'hFFFF_FFFE};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h1111, 32'h2222);
            total++;
            if ({aluResult, HI_OUT, LO_OUT} !== {exp[i], 32'h1111, 32'h2222})
                $display("FAIL arith_op%h: got %h required %h", ops[i], aluResult, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_shifts;
        logic [5:0]  ops [4] = '{6'h0A, 6'h0B, 6'h0C, 6'h0F};
        logic [31:0] exp [4] = '{32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'hF800_0001};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 32'h24, 32'h8000_0010, 5'd4, 32'h3, 32'h4);
            total++;
            if ({aluResult, HI_OUT, LO_OUT} !== {exp[i], 32'h3, 32'h4})
                $display("FAIL shift_op%h: got %h required %h", ops[i], aluResult, exp[i]);
            else passed++;
        end
    endtask

    task automatic test_muldiv;
        logic [5:0]  ops [6] = '{6'h15, 6'h16, 6'h17, 6'h17, 6'h18, 6'h17};
        logic [31:0] as_ [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h55, 32'h8000_0000};
        logic [31:0] bs  [6] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF};
`ifdef MULDIV_EN
        logic [63:0] exp [6] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFA}, {32'd2, 32'hFFFF_FFFA},
                                 {32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'hFFFF_FFF9, 32'hFFFF_FFFF},
                                 {32'h55, 32'hFFFF_FFFF}, {32'd0, 32'h8000_0000}};
`else
        logic [63:0] exp [6] = '{6{{32'hAAAA, 32'hBBBB}}};
`endif
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], as_[i], bs[i], 5'd0, 32'hAAAA, 32'hBBBB);
            total++;
            if ({aluResult, HI_OUT, LO_OUT} !== {32'd0, exp[i]})
                $display("FAIL muldiv_%0d: got %h required %h", i, {aluResult, HI_OUT, LO_OUT}, {32'd0, exp[i]});
            else passed++;
        end
    endtask

    task automatic test_hilo;
        drive(6'h13, 32'h1234, 32'h0, 5'd0, 32'h9, 32'h77);
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== {32'd0, 32'h1234, 32'h77})
            $display("FAIL mthi: got %h required %h", {aluResult, HI_OUT, LO_OUT}, {32'd0, 32'h1234, 32'h77});
        else passed++;
        drive(6'h11, 32'h0, 32'h0, 5'd0, 32'h1234, 32'h77);
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== {32'h1234, 32'h1234, 32'h77})
            $display("FAIL mfhi: got %h required %h", {aluResult, HI_OUT, LO_OUT}, {32'h1234, 32'h1234, 32'h77});
        else passed++;
        drive(6'h10, 32'h0, 32'hABCD, 5'd0, 32'h1, 32'h2);
        total++;
        if ({aluResult, HI_OUT, LO_OUT} !== {32'hABCD_0000, 32'h1, 32'h2})
            $display("FAIL lui: got %h required %h", aluResult, 32'hABCD_0000);
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] r, h, l;
        logic [5:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [4:0]  s;
        for (int i = 0; i < 400; i++) begin
            op = 6'($urandom_range(0, 31));
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
            s  = 5'($urandom);
            hi = $urandom;
            lo = $urandom;
            model(op, a, b, s, hi, lo, r, h, l);
            drive(op, a, b, s, hi, lo);
            total++;
            if ({aluResult, HI_OUT, LO_OUT} !== {r, h, l})
                $display("FAIL rand op=%h a=%h b=%h s=%0d: got %h required %h",
                         op, a, b, s, {aluResult, HI_OUT, LO_OUT}, {r, h, l});
            else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_shifts;
        test_muldiv;
        test_hilo;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
